cluster_clock_gate_ctrl: RTL and testbench
==========================================

Name: cluster_clock_gate_ctrl

Overview:
- Multi-channel clock-gating controller for cluster peripherals and accelerators.
- Each channel has an idle-detect FSM with programmable hysteresis. After N idle cycles the FSM gates its sub-clock automatically.
- A channel wakes on activity or on an explicit req/ready handshake, with a fixed settle delay before ready.
- Each channel has its own latch-based glitch-free gate. All channels sit between the cluster clock root and the per-unit clock domains.

Parameters:
- NUM_CH, 4, number of gated clock channels (1..32).
- CNT_W, 8, width of the idle counter and of cfg_idle_i.
- WAKE_CYCLES, 2, cycles the clock runs in WAKE before ready_o rises (>=1).

Ports:
- clk_i  in  1  cluster clock; also the source of every gated output.
- rst_i  in  1  synchronous, active-high reset.
- test_en_i  in  1  scan/test override; forces every clk_o running.
- busy_i  in  NUM_CH  per-channel activity; 1 = unit needs its clock.
- wake_req_i  in  NUM_CH  explicit wake request; held by the requester until ready_o.
- cfg_auto_en_i  in  NUM_CH  1 = auto-gating allowed; 0 = channel kept running.
- cfg_idle_i  in  CNT_W  idle threshold, shared by all channels, sampled every cycle.
- ready_o  out  NUM_CH  channel clock is running and stable.
- gated_o  out  NUM_CH  channel clock is currently gated (status).
- clk_en_o  out  NUM_CH  registered per-channel enable, exported for observability.
- clk_o  out  NUM_CH  gated clock outputs.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - every channel goes to RUN with cnt=0;
  - clk_en_o=all 1s, ready_o=all 1s, gated_o=0;
  - reset overrides any state, including mid-WAKE and mid-IDLE_WAIT.
- Channels are fully independent. Per-channel FSM, with act = busy_i[c] | wake_req_i[c]:
  - RUN: clk_en=1. If !act and cfg_auto_en_i[c] -> IDLE_WAIT with cnt=0.
  - IDLE_WAIT: clk_en=1.
    - If act or !cfg_auto_en_i[c] -> RUN.
    - Else if cnt >= cfg_idle_i -> GATED.
    - Else cnt += 1.
    - cfg_idle_i=0 gives exactly 1 cycle in IDLE_WAIT. The threshold is checked live, so lowering it mid-count gates on the next cycle.
  - GATED: clk_en=0. If act or !cfg_auto_en_i[c] -> WAKE with cnt=0.
  - WAKE: clk_en=1. cnt += 1; when cnt == WAKE_CYCLES-1 -> RUN. Activity is ignored while in WAKE.
- clk_en_o is registered from next-state, so the enable changes on the same edge the state changes.
- ready_o[c] = state in {RUN, IDLE_WAIT}; gated_o[c] = (state == GATED).
- Wake latency: a request seen while GATED reaches ready_o WAKE_CYCLES+1 edges later. A request while in RUN/IDLE_WAIT sees ready_o already high (0 latency).
- Counter never wraps; cnt is held once the transition fires.
- Gate cell, per channel:
  - latch en_l transparent while clk_i==0, en_l = clk_en_o[c] | test_en_i;
  - clk_o[c] = clk_i & en_l;
  - no glitch on clk_o when the enable changes in the high phase;
  - test_en_i does not alter the FSM, ready_o or gated_o.
- Simultaneous events: busy_i and wake_req_i both high act the same as either alone. When the threshold is reached in the same cycle as act, RUN wins.

Optional Feature:
- Macro CLK_GATE_STATS_EN.
- When defined:
  - per-channel saturating 16-bit counter of cycles spent in GATED;
  - added ports: stats_clr_i in 1 (synchronous clear of all counters, priority over increment) and stats_gated_cnt_o out NUM_CH*16;
  - counters reset to 0 and saturate at 0xFFFF.
- When undefined: no counters and no extra ports; all other behaviour identical.

Test Plan:
- Reset release: rst_i high 3 cycles, busy_i=0, cfg_auto_en_i=all 1s, cfg_idle_i=4 -> ready_o=all 1s. IDLE_WAIT is entered 1 cycle after release; gated_o rises 6 edges after release (1 + 5 cycles of cnt 0..4); clk_o then has no pulses.
- Wake handshake, WAKE_CYCLES=2, ch1 gated: pulse wake_req_i[1] and hold it -> clk_en_o[1]=1 after 1 edge; ready_o[1]=1 after 3 edges; other channels stay unchanged.
- Hysteresis: cfg_idle_i=10; drop busy for 5 cycles, then raise busy_i for 1 cycle -> channel returns to RUN and never gates. It then gates only after 11 further idle cycles.
- cfg_idle_i=0 and cfg_auto_en_i toggling: gating occurs 2 edges after busy falls. Clearing cfg_auto_en_i while GATED -> WAKE, then RUN, and the channel stays in RUN.
- test_en_i=1 while all channels are GATED -> clk_o toggles every cycle while gated_o stays all 1s. Drop test_en_i during the clk_i-high phase -> no truncated pulse on clk_o.
- With CLK_GATE_STATS_EN: gate ch0 for 70000 cycles -> stats_gated_cnt_o[15:0]=0xFFFF. Assert stats_clr_i -> 0x0000 on the next edge.

Source files
------------

// File: rtl/cluster_clock_gate_ctrl.sv
// Multi-channel idle-detect clock-gating controller with per-channel glitch-free gates.
// Optional gated-cycle statistics are enabled by defining CLK_GATE_STATS_EN.
module cluster_clock_gate_ctrl #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 8,
   parameter int WAKE_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              test_en_i,
   input  logic [NUM_CH-1:0] busy_i,
   input  logic [NUM_CH-1:0] wake_req_i,
   input  logic [NUM_CH-1:0] cfg_auto_en_i,
   input  logic [CNT_W-1:0]  cfg_idle_i,
`ifdef CLK_GATE_STATS_EN
   input  logic                 stats_clr_i,
   output logic [NUM_CH*16-1:0] stats_gated_cnt_o,
`endif
   output logic [NUM_CH-1:0] ready_o,
   output logic [NUM_CH-1:0] gated_o,
   output logic [NUM_CH-1:0] clk_en_o,
   output logic [NUM_CH-1:0] clk_o
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_GATED = 2'd2;
   localparam logic [1:0] ST_WAKE  = 2'd3;

   localparam logic [CNT_W-1:0] WAKE_LAST =
      CNT_W'(WAKE_CYCLES - 1);

   logic [NUM_CH-1:0][1:0]       state_q;
   logic [NUM_CH-1:0][1:0]       state_d;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_d;
   logic [NUM_CH-1:0]            clk_en_q;
   logic [NUM_CH-1:0]            clk_en_d;
   logic [NUM_CH-1:0]            act;
   logic [NUM_CH-1:0]            stay_on;

   assign act     = busy_i | wake_req_i;
   assign stay_on = act | ~cfg_auto_en_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int c = 0; c < NUM_CH; c++) begin
         unique case (state_q[c])
            ST_RUN: begin
               if (!stay_on[c]) begin
                  state_d[c] = ST_IDLE;
                  cnt_d[c]   = '0;
               end
            end
            ST_IDLE: begin
               // activity beats an expiring threshold
               if (stay_on[c]) begin
                  state_d[c] = ST_RUN;
               end else if (cnt_q[c] >= cfg_idle_i) begin
                  state_d[c] = ST_GATED;
               end else begin
                  cnt_d[c] = cnt_q[c] + 1'b1;
               end
            end
            ST_GATED: begin
               if (stay_on[c]) begin
                  state_d[c] = ST_WAKE;
                  cnt_d[c]   = '0;
               end
            end
            ST_WAKE: begin
               if (cnt_q[c] == WAKE_LAST) begin
                  state_d[c] = ST_RUN;
               end else begin
                  cnt_d[c] = cnt_q[c] + 1'b1;
               end
            end
            default: begin
               state_d[c] = ST_RUN;
               cnt_d[c]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      clk_en_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         clk_en_d[c] = (state_d[c] != ST_GATED);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= {NUM_CH{ST_RUN}};
         cnt_q    <= '0;
         clk_en_q <= '1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clk_en_q <= clk_en_d;
      end
   end

   always_comb begin
      ready_o = '0;
      gated_o = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ready_o[c] = (state_q[c] == ST_RUN) ||
                      (state_q[c] == ST_IDLE);
         gated_o[c] = (state_q[c] == ST_GATED);
      end
   end

   assign clk_en_o = clk_en_q;

   // enable only changes while clk_i is low, so clk_o never glitches
   for (genvar g = 0; g < NUM_CH; g++) begin : gen_gate
      logic en_l;
      always_latch begin
         if (!clk_i) begin
            en_l = clk_en_q[g] | test_en_i;
         end
      end
      assign clk_o[g] = clk_i & en_l;
   end

`ifdef CLK_GATE_STATS_EN
   logic [NUM_CH-1:0][15:0] stat_q;
   logic [NUM_CH-1:0][15:0] stat_d;

   always_comb begin
      stat_d = stat_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (stats_clr_i) begin
            stat_d[c] = '0;
         end else if (gated_o[c] &&
                      (stat_q[c] != 16'hFFFF)) begin
            stat_d[c] = stat_q[c] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stats_gated_cnt_o = stat_q;
`endif

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Self-checking bench for cluster_clock_gate_ctrl.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_cluster_clock_gate_ctrl;

   localparam int NUM_CH      = 4;
   localparam int CNT_W       = 8;
   localparam int WAKE_CYCLES = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              test_en;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] wake_req;
   logic [NUM_CH-1:0] auto_en;
   logic [CNT_W-1:0]  cfg_idle;
   logic [NUM_CH-1:0] ready_o;
   logic [NUM_CH-1:0] gated_o;
   logic [NUM_CH-1:0] clk_en_o;
   logic [NUM_CH-1:0] clk_o;
`ifdef CLK_GATE_STATS_EN
   logic                 stats_clr;
   logic [NUM_CH*16-1:0] stats_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // model: idle_len < 0 means running with activity,
   // wake_left > 0 means settling after a wake
   int m_idle [NUM_CH];
   bit m_gated[NUM_CH];
   int m_wake [NUM_CH];

   cluster_clock_gate_ctrl #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .WAKE_CYCLES(WAKE_CYCLES)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .test_en_i    (test_en),
      .busy_i       (busy),
      .wake_req_i   (wake_req),
      .cfg_auto_en_i(auto_en),
      .cfg_idle_i   (cfg_idle),
`ifdef CLK_GATE_STATS_EN
      .stats_clr_i      (stats_clr),
      .stats_gated_cnt_o(stats_cnt),
`endif
      .ready_o      (ready_o),
      .gated_o      (gated_o),
      .clk_en_o     (clk_en_o),
      .clk_o        (clk_o)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      bit keep;
      for (int c = 0; c < NUM_CH; c++) begin
         keep = busy[c] | wake_req[c] | ~auto_en[c];
         if (rst) begin
            m_idle[c]  = -1;
            m_gated[c] = 1'b0;
            m_wake[c]  = 0;
         end else if (m_wake[c] > 0) begin
            m_wake[c]--;
         end else if (m_gated[c]) begin
            if (keep) begin
               m_gated[c] = 1'b0;
               m_wake[c]  = WAKE_CYCLES;
               m_idle[c]  = -1;
            end
         end else if (keep) begin
            m_idle[c] = -1;
         end else if (m_idle[c] < 0) begin
            m_idle[c] = 0;
         end else if (m_idle[c] >= int'(cfg_idle)) begin
            m_gated[c] = 1'b1;
         end else begin
            m_idle[c]++;
         end
      end
   endtask

   function automatic logic [NUM_CH-1:0] exp_ready();
      logic [NUM_CH-1:0] r;
      for (int c = 0; c < NUM_CH; c++)
         r[c] = !m_gated[c] && (m_wake[c] == 0);
      return r;
   endfunction

   function automatic logic [NUM_CH-1:0] exp_gated();
      logic [NUM_CH-1:0] r;
      for (int c = 0; c < NUM_CH; c++)
         r[c] = m_gated[c];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      int edges;
      rst = 1'b1; test_en = 1'b0;
      busy = '0; wake_req = '0;
      auto_en = '1; cfg_idle = 8'd4;
      repeat (3) tick();
      n_cmp++;
      if (ready_o !== 4'hF) begin
         n_bad++;
         $display("FAIL reset_ready got %b want 1111", ready_o);
      end
      n_cmp++;
      if (gated_o !== 4'h0) begin
         n_bad++;
         $display("FAIL reset_gated got %b want 0000", gated_o);
      end
      n_cmp++;
      if (clk_en_o !== 4'hF) begin
         n_bad++;
         $display("FAIL reset_clken got %b want 1111", clk_en_o);
      end
      rst = 1'b0;
      tick();
      edges = 1;
      n_cmp++;
      if (ready_o !== 4'hF || gated_o !== 4'h0) begin
         n_bad++;
         $display("FAIL idle_entry got r=%b g=%b want r=1111 g=0000",
                  ready_o, gated_o);
      end
      while (gated_o !== 4'hF && edges < 40) begin
         tick();
         edges++;
      end
      n_cmp++;
      if (edges != 6) begin
         n_bad++;
         $display("FAIL gate_latency got %0d edges want 6", edges);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (clk_o !== 4'h0) begin
            n_bad++;
            $display("FAIL gated_clk got %b want 0000", clk_o);
         end
         tick();
      end
   endtask

   task automatic test_wake();
      wake_req[1] = 1'b1;
      tick();
      n_cmp++;
      if (clk_en_o[1] !== 1'b1 || ready_o[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL wake_e1 got en=%b rdy=%b want en=1 rdy=0",
                  clk_en_o[1], ready_o[1]);
      end
      tick();
      n_cmp++;
      if (ready_o[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL wake_e2 got rdy=%b want 0", ready_o[1]);
      end
      tick();
      n_cmp++;
      if (ready_o[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL wake_e3 got rdy=%b want 1", ready_o[1]);
      end
      n_cmp++;
      if (gated_o !== 4'b1101) begin
         n_bad++;
         $display("FAIL wake_others got %b want 1101", gated_o);
      end
      wake_req[1] = 1'b0;
   endtask

   task automatic test_hysteresis();
      int edges;
      bit seen;
      cfg_idle = 8'd10;
      busy = '1;
      repeat (5) tick();
      n_cmp++;
      if (ready_o !== 4'hF) begin
         n_bad++;
         $display("FAIL hyst_awake got %b want 1111", ready_o);
      end
      seen = 1'b0;
      busy[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         seen |= gated_o[0];
      end
      busy[0] = 1'b1;
      tick();
      seen |= gated_o[0];
      busy[0] = 1'b0;
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL hyst_early got gated=1 want 0");
      end
      edges = 0;
      while (gated_o[0] !== 1'b1 && edges < 40) begin
         tick();
         edges++;
      end
      n_cmp++;
      if (edges != 12) begin
         n_bad++;
         $display("FAIL hyst_latency got %0d edges want 12", edges);
      end
      n_cmp++;
      if (ready_o[3:1] !== 3'b111) begin
         n_bad++;
         $display("FAIL hyst_others got %b want 111", ready_o[3:1]);
      end
   endtask

   task automatic test_idle_zero();
      cfg_idle = 8'd0;
      busy[2] = 1'b0;
      tick();
      n_cmp++;
      if (gated_o[2] !== 1'b0) begin
         n_bad++;
         $display("FAIL idle0_e1 got %b want 0", gated_o[2]);
      end
      tick();
      n_cmp++;
      if (gated_o[2] !== 1'b1) begin
         n_bad++;
         $display("FAIL idle0_e2 got %b want 1", gated_o[2]);
      end
      auto_en[2] = 1'b0;
      tick();
      n_cmp++;
      if (gated_o[2] !== 1'b0 || ready_o[2] !== 1'b0 ||
          clk_en_o[2] !== 1'b1) begin
         n_bad++;
         $display("FAIL noauto_wake got g=%b r=%b e=%b want 0 0 1",
                  gated_o[2], ready_o[2], clk_en_o[2]);
      end
      tick();
      n_cmp++;
      if (ready_o[2] !== 1'b0) begin
         n_bad++;
         $display("FAIL noauto_e2 got %b want 0", ready_o[2]);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++;
         if (ready_o[2] !== 1'b1 || gated_o[2] !== 1'b0) begin
            n_bad++;
            $display("FAIL noauto_run got r=%b g=%b want 1 0",
                     ready_o[2], gated_o[2]);
         end
      end
      auto_en[2] = 1'b1;
   endtask

   task automatic test_test_en();
      int edges;
      busy = '0; wake_req = '0;
      auto_en = '1; cfg_idle = 8'd1;
      edges = 0;
      while (gated_o !== 4'hF && edges < 40) begin
         tick();
         edges++;
      end
      n_cmp++;
      if (gated_o !== 4'hF) begin
         n_bad++;
         $display("FAIL te_allgated got %b want 1111", gated_o);
      end
      tick();
      test_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (clk_o !== 4'hF || gated_o !== 4'hF) begin
            n_bad++;
            $display("FAIL te_high got clk=%b g=%b want 1111 1111",
                     clk_o, gated_o);
         end
         @(negedge clk);
         #1;
         n_cmp++;
         if (clk_o !== 4'h0) begin
            n_bad++;
            $display("FAIL te_low got %b want 0000", clk_o);
         end
      end
      tick();
      #1;
      test_en = 1'b0;
      #2;
      n_cmp++;
      if (clk_o !== 4'hF) begin
         n_bad++;
         $display("FAIL te_trunc got %b want 1111", clk_o);
      end
      tick();
      n_cmp++;
      if (clk_o !== 4'h0 || ready_o !== 4'h0) begin
         n_bad++;
         $display("FAIL te_off got clk=%b r=%b want 0000 0000",
                  clk_o, ready_o);
      end
   endtask

`ifdef CLK_GATE_STATS_EN
   task automatic test_stats();
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      repeat (70000) tick();
      n_cmp++;
      if (stats_cnt[15:0] !== 16'hFFFF) begin
         n_bad++;
         $display("FAIL stats_sat got %h want ffff", stats_cnt[15:0]);
      end
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      n_cmp++;
      if (stats_cnt[15:0] !== 16'h0000) begin
         n_bad++;
         $display("FAIL stats_clr got %h want 0000", stats_cnt[15:0]);
      end
   endtask
`endif

   task automatic test_random();
      logic [NUM_CH-1:0] er;
      logic [NUM_CH-1:0] eg;
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         test_en = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 7) == 0)
            cfg_idle = CNT_W'($urandom_range(0, 6));
         for (int c = 0; c < NUM_CH; c++) begin
            busy[c] = ($urandom_range(0, 5) == 0);
            auto_en[c] = ($urandom_range(0, 11) != 0);
            if (!(wake_req[c] && !ready_o[c]))
               wake_req[c] = ($urandom_range(0, 9) == 0);
         end
         tick();
         er = exp_ready();
         eg = exp_gated();
         n_cmp++;
         if (ready_o !== er) begin
            n_bad++;
            $display("FAIL rnd_ready cyc %0d got %b want %b",
                     n, ready_o, er);
         end
         n_cmp++;
         if (gated_o !== eg) begin
            n_bad++;
            $display("FAIL rnd_gated cyc %0d got %b want %b",
                     n, gated_o, eg);
         end
         n_cmp++;
         if (clk_en_o !== ~eg) begin
            n_bad++;
            $display("FAIL rnd_clken cyc %0d got %b want %b",
                     n, clk_en_o, ~eg);
         end
      end
      rst = 1'b0;
      test_en = 1'b0;
   endtask

   initial begin
`ifdef CLK_GATE_STATS_EN
      stats_clr = 1'b0;
`endif
      for (int c = 0; c < NUM_CH; c++) begin
         m_idle[c]  = -1;
         m_gated[c] = 1'b0;
         m_wake[c]  = 0;
      end
      test_reset();
      test_wake();
      test_hysteresis();
      test_idle_zero();
      test_test_en();
`ifdef CLK_GATE_STATS_EN
      test_stats();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
